regfile_wr_sched: RTL and testbench

//  Write-port scheduler for the 32x32 register file (2 comb read ports, negedge write).

---
 rtl/regfile_wr_sched.sv | 97 +++++++++
 tb/tb_regfile_wr_sched.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_sched.sv
// regfile_wr_sched: zero-fills the register file after reset, then shares its write port between core writeback and a debug channel.
// Optional debug read channel is enabled by defining REGFILE_DBG_RD_EN.
module regfile_wr_sched #(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_core_wr_en,
    input  logic [ADDR_W-1:0] i_core_wr_addr,
    input  logic [DATA_W-1:0] i_core_wr_dat,
    output logic              o_core_stall,
    input  logic              i_dbg_valid,
    output logic              o_dbg_ready,
    input  logic              i_dbg_we,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic [DATA_W-1:0] i_dbg_dat,
`ifdef REGFILE_DBG_RD_EN
    output logic [ADDR_W-1:0] o_dbg_rd_addr,
    input  logic [DATA_W-1:0] i_dbg_rd_dat,
    output logic [DATA_W-1:0] o_dbg_rdata,
    output logic              o_dbg_rvalid,
`endif
    output logic              o_rf_wr_en,
    output logic [ADDR_W-1:0] o_rf_wr_addr,
    output logic [DATA_W-1:0] o_rf_wr_dat,
    output logic              o_init_done
);
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [3:0]        starve_cnt;
    logic              init_done;
    logic              run;
    logic              dbg_win;
    logic              dbg_wr;

    always_comb begin
        run          = state == RUN;
        dbg_win      = run & i_dbg_valid & (!i_core_wr_en | starve_cnt == LIM);
`ifdef REGFILE_DBG_RD_EN
        dbg_wr       = dbg_win & i_dbg_we;
`else
        dbg_wr       = dbg_win;
`endif
        o_dbg_ready  = dbg_win;
        o_core_stall = !run | (dbg_win & i_core_wr_en);
        // A granted debug request owns the port even for reads or x0, so the stalled core never writes.
        o_rf_wr_en   = rst_n & (!run | (dbg_win ? dbg_wr & (i_dbg_addr != '0) : i_core_wr_en));
        o_rf_wr_addr = !run ? clr_ptr : dbg_win ? i_dbg_addr : i_core_wr_addr;
        o_rf_wr_dat  = !run ? '0 : dbg_win ? i_dbg_dat : i_core_wr_dat;
        o_init_done  = init_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR;
            clr_ptr    <= ADDR_W'(1);
            starve_cnt <= '0;
            init_done  <= 1'b0;
        end else begin
            if (!run) begin
                clr_ptr <= clr_ptr + ADDR_W'(1);
                if (clr_ptr == LAST) begin
                    state     <= RUN;
                    init_done <= 1'b1;
                end
            end
            starve_cnt <= (run & i_dbg_valid & !dbg_win)
                        ? (starve_cnt == LIM ? starve_cnt : starve_cnt + 4'd1) : '0;
        end
    end

`ifdef REGFILE_DBG_RD_EN
    assign o_dbg_rd_addr = i_dbg_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_dbg_rdata  <= '0;
            o_dbg_rvalid <= 1'b0;
        end else begin
            o_dbg_rvalid <= dbg_win & !i_dbg_we;
            if (dbg_win & !i_dbg_we)
                o_dbg_rdata <= i_dbg_rd_dat;
        end
    end
`else
    logic unused_dbg_we;
    assign unused_dbg_we = i_dbg_we;
`endif
endmodule

// File: tb/tb_regfile_wr_sched.sv
// tb_regfile_wr_sched: directed and random stimulus against a cycle-level reference model of the write scheduler.
module tb_regfile_wr_sched;
    localparam int NR  = 32;
    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_en = 1'b0;
    logic [4:0]  core_addr = '0;
    logic [31:0] core_dat = '0;
    logic        dv = 1'b0;
    logic        dwe = 1'b0;
    logic [4:0]  daddr = '0;
    logic [31:0] ddat = '0;
    logic        stall, ready, wr_en, init_done;
    logic [4:0]  wr_addr;
    logic [31:0] wr_dat;
    logic [31:0] mrf [NR];
    int          total = 0;
    int          bad = 0;
    int          sweep = 0;
    int          waited = 0;
    bit          last_win = 1'b0;
    bit          rdy_seen = 1'b0;
`ifdef REGFILE_DBG_RD_EN
    logic [4:0]  rd_addr;
    logic [31:0] rd_dat, rdata;
    logic        rvalid;
    bit          exp_rvalid = 1'b0;
    logic [31:0] exp_rdata = '0;
    assign rd_dat = mrf[daddr];
`endif

    regfile_wr_sched dut (
        .clk(clk), .rst_n(rst_n),
        .i_core_wr_en(core_en), .i_core_wr_addr(core_addr), .i_core_wr_dat(core_dat),
        .o_core_stall(stall),
        .i_dbg_valid(dv), .o_dbg_ready(ready), .i_dbg_we(dwe), .i_dbg_addr(daddr), .i_dbg_dat(ddat),
`ifdef REGFILE_DBG_RD_EN
        .o_dbg_rd_addr(rd_addr), .i_dbg_rd_dat(rd_dat), .o_dbg_rdata(rdata), .o_dbg_rvalid(rvalid),
`endif
        .o_rf_wr_en(wr_en), .o_rf_wr_addr(wr_addr), .o_rf_wr_dat(wr_dat), .o_init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One cycle of the reference: clear sweep first, then grant by priority and wait budget.
    task automatic check_cycle();
        bit win, wr, en;
        if (sweep < NR - 1) begin
            chk("clr_en", 32'(wr_en), 32'd1);
            chk("clr_addr", 32'(wr_addr), 32'(sweep + 1));
            chk("clr_dat", wr_dat, 32'd0);
            chk("clr_stall", 32'(stall), 32'd1);
            chk("clr_ready", 32'(ready), 32'd0);
            chk("clr_done", 32'(init_done), 32'd0);
            mrf[sweep + 1] = '0;
            sweep++;
            last_win = 1'b0;
        end else begin
            win = dv && (!core_en || waited >= LIM);
`ifdef REGFILE_DBG_RD_EN
            wr = win && dwe;
`else
            wr = win;
`endif
            en = win ? (wr && daddr != 0) : core_en;
            chk("ready", 32'(ready), 32'(win));
            chk("stall", 32'(stall), 32'(win && core_en));
            chk("wr_en", 32'(wr_en), 32'(en));
            chk("done", 32'(init_done), 32'd1);
            if (en) begin
                chk("wr_addr", 32'(wr_addr), 32'(win ? daddr : core_addr));
                chk("wr_dat", wr_dat, win ? ddat : core_dat);
                mrf[win ? daddr : core_addr] = win ? ddat : core_dat;
            end
`ifdef REGFILE_DBG_RD_EN
            chk("rvalid", 32'(rvalid), 32'(exp_rvalid));
            if (exp_rvalid) chk("rdata", rdata, exp_rdata);
            exp_rvalid = win && !dwe;
            if (exp_rvalid) exp_rdata = mrf[daddr];
`endif
            waited = (dv && !win) ? waited + 1 : 0;
            last_win = win;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        rdy_seen = ready;
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        core_en = 1'b0;
        dv = 1'b0;
        @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_done", 32'(init_done), 32'd0);
`ifdef REGFILE_DBG_RD_EN
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        exp_rvalid = 1'b0;
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep = 0;
        waited = 0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < NR; i++) mrf[i] = '0;
        do_reset();
        repeat (NR) tick();
        core_en = 1'b1; core_addr = 5'd5; core_dat = 32'hDEADBEEF;
        tick();
        dv = 1'b1; dwe = 1'b1; daddr = 5'd7; ddat = 32'h1234;
        n = 0;
        for (int i = 0; i < 20 && !rdy_seen; i++) begin
            core_addr = 5'($urandom);
            core_dat = $urandom;
            tick();
            if (!rdy_seen) n++;
        end
        chk("starve_wait", 32'(n), 32'(LIM));
        daddr = 5'd8; ddat = 32'h55;
        tick();
        dv = 1'b0;
        core_en = 1'b0;
        tick();
        dv = 1'b1; daddr = 5'd0; ddat = 32'hFFFF;
        tick();
        dv = 1'b0;
`ifdef REGFILE_DBG_RD_EN
        core_en = 1'b1; core_addr = 5'd9; core_dat = 32'hA5A5A5A5;
        tick();
        core_en = 1'b0; dv = 1'b1; dwe = 1'b0; daddr = 5'd9;
        tick();
        dv = 1'b0;
        tick();
`endif
        for (int i = 0; i < 400; i++) begin
            core_en = $urandom_range(0, 9) < 7;
            core_addr = 5'($urandom);
            core_dat = $urandom;
            if (!dv || last_win) begin
                dv = 1'($urandom_range(0, 1));
                dwe = 1'($urandom_range(0, 1));
                daddr = 5'($urandom);
                ddat = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                dv = 1'b0;
            end
            tick();
        end
        do_reset();
        repeat (9) tick();
        do_reset();
        repeat (NR + 2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
